// File: rtl/cordic_arb_pkg.sv
// Shared definitions for the CORDIC arbiter slice.
// Holds parameter defaults and the tag record that follows each operation
// through the core-latency shadow pipeline.
package cordic_arb_pkg;

  localparam int unsigned NREQ_DEF    = 4;
  localparam int unsigned WIDTH_DEF   = 48;
  localparam int unsigned LATENCY_DEF = 20;

  // Wide enough for any requester count the 6-bit counters can sensibly serve.
  localparam int unsigned TagIdxW = 6;

  typedef struct packed {
    logic               valid;
    logic [TagIdxW-1:0] idx;
  } tag_t;

endpackage

// File: rtl/cordic_rr_arbiter.sv
// Round-robin grant logic, purely combinational.
// Ports:
//   req_i  - per-requester valid
//   ptr_i  - requester index the search starts from
//   hold_i - suppress all grants
//   gnt_o  - one-hot grant (all zero when held or nothing requested)
module cordic_rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PtrW = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PtrW-1:0] ptr_i,
  input  logic            hold_i,
  output logic [NREQ-1:0] gnt_o
);

  logic            found;
  logic [PtrW-1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = PtrW'((32'(ptr_i) + k) % NREQ);
      if (!hold_i && !found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one fixed-latency vectoring CORDIC core among NREQ requesters.
// Ports:
//   CLK, RST             - clock, synchronous active-high reset
//   HOLD                 - block new grants; in-flight work still drains
//   REQ_VALID/X/Y        - per-requester operands (packed, WIDTH per requester)
//   REQ_READY            - one-hot grant, combinational
//   CORE_X/Y/VALID       - registered issue towards the core
//   CORE_XN/AN/RDYOUT    - core results, expected LATENCY cycles after CORE_VALID
//   RES_VALID/MAG/ANG    - registered result routed to the owning requester
//   INFLIGHT             - operations issued but not yet retired
//   TAG_ERR              - sticky: core strobe disagreed with the tag pipeline
module cordic_arbiter
  import cordic_arb_pkg::*;
#(
  parameter int unsigned NREQ    = NREQ_DEF,
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned LATENCY = LATENCY_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  HOLD,
  input  logic [NREQ-1:0]       REQ_VALID,
  input  logic [NREQ*WIDTH-1:0] REQ_X,
  input  logic [NREQ*WIDTH-1:0] REQ_Y,
  output logic [NREQ-1:0]       REQ_READY,
  output logic [WIDTH-1:0]      CORE_X,
  output logic [WIDTH-1:0]      CORE_Y,
  output logic                  CORE_VALID,
  input  logic [WIDTH-1:0]      CORE_XN,
  input  logic [WIDTH-1:0]      CORE_AN,
  input  logic                  CORE_RDYOUT,
  output logic [NREQ-1:0]       RES_VALID,
  output logic [WIDTH-1:0]      RES_MAG,
  output logic [WIDTH-1:0]      RES_ANG,
  output logic [5:0]            INFLIGHT,
  output logic                  TAG_ERR
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0]  gnt;
  logic [PtrW-1:0]  gnt_idx;
  logic             transfer;
  logic [WIDTH-1:0] core_x_q, core_x_d, core_y_q, core_y_d;
  logic             core_valid_q, core_valid_d;
  logic [PtrW-1:0]  core_idx_q, core_idx_d;
  tag_t             tag_q [LATENCY];
  tag_t             tag_d [LATENCY];
  tag_t             tag_last;
  logic             hit;
  logic [NREQ-1:0]  res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_mag_q, res_mag_d, res_ang_q, res_ang_d;
  logic [5:0]       inflight_q, inflight_d;
  logic [5:0]       mask_q, mask_d;
  logic             tag_err_q, tag_err_d;

  // Reset gates the grant so nothing is accepted in a reset cycle.
  cordic_rr_arbiter #(
    .NREQ (NREQ),
    .PtrW (PtrW)
  ) u_rr (
    .req_i  (REQ_VALID),
    .ptr_i  (ptr_q),
    .hold_i (HOLD | RST),
    .gnt_o  (gnt)
  );

  assign REQ_READY = gnt;

  always_comb begin
    gnt_idx  = '0;
    core_x_d = core_x_q;
    core_y_d = core_y_q;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_idx  = PtrW'(i);
        core_x_d = REQ_X[i*WIDTH +: WIDTH];
        core_y_d = REQ_Y[i*WIDTH +: WIDTH];
      end
    end
    transfer     = |gnt;
    core_valid_d = transfer;
    core_idx_d   = gnt_idx;
    ptr_d        = ptr_q;
    if (transfer) begin
      ptr_d = (gnt_idx == PtrW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Tag enters alongside CORE_VALID so the last stage lines up with CORE_RDYOUT.
  always_comb begin
    tag_d[0].valid = core_valid_q;
    tag_d[0].idx   = TagIdxW'(core_idx_q);
    for (int i = 1; i < LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  assign tag_last = tag_q[LATENCY-1];
  assign hit      = tag_last.valid & CORE_RDYOUT;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      res_valid_d[i] = hit && (tag_last.idx == TagIdxW'(i));
    end
    res_mag_d = hit ? CORE_XN : res_mag_q;
    res_ang_d = hit ? CORE_AN : res_ang_q;

    inflight_d = inflight_q;
    case ({core_valid_q, tag_last.valid})
      2'b10:   inflight_d = inflight_q + 6'd1;
      2'b01:   inflight_d = inflight_q - 6'd1;
      default: inflight_d = inflight_q;
    endcase

    // Strobes from work discarded by reset may still arrive for LATENCY cycles.
    mask_d    = (mask_q != 6'd0) ? mask_q - 6'd1 : mask_q;
    tag_err_d = tag_err_q
              | (tag_last.valid & ~CORE_RDYOUT)
              | (CORE_RDYOUT & ~tag_last.valid & (mask_q == 6'd0));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q        <= '0;
      core_x_q     <= '0;
      core_y_q     <= '0;
      core_valid_q <= 1'b0;
      core_idx_q   <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_q[i] <= '0;
      end
      res_valid_q  <= '0;
      res_mag_q    <= '0;
      res_ang_q    <= '0;
      inflight_q   <= '0;
      mask_q       <= 6'(LATENCY);
      tag_err_q    <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      core_x_q     <= core_x_d;
      core_y_q     <= core_y_d;
      core_valid_q <= core_valid_d;
      core_idx_q   <= core_idx_d;
      for (int i = 0; i < LATENCY; i++) begin
        tag_q[i] <= tag_d[i];
      end
      res_valid_q  <= res_valid_d;
      res_mag_q    <= res_mag_d;
      res_ang_q    <= res_ang_d;
      inflight_q   <= inflight_d;
      mask_q       <= mask_d;
      tag_err_q    <= tag_err_d;
    end
  end

  assign CORE_X     = core_x_q;
  assign CORE_Y     = core_y_q;
  assign CORE_VALID = core_valid_q;
  assign RES_VALID  = res_valid_q;
  assign RES_MAG    = res_mag_q;
  assign RES_ANG    = res_ang_q;
  assign INFLIGHT   = inflight_q;
  assign TAG_ERR    = tag_err_q;

endmodule
